sdc_drive_arbiter: RTL and testbench

- Sits between the machine core's multi-drive sector request bits (floppies, SCSI) and the single sd_rw sector engine.
- Arbitrates per-drive read/write requests round-robin and relocates each drive's LBA into its own SD card region (base + offset).
- Gates the sector-data strobe to the granted drive only.
- Replaces the fixed "upper LBA byte = request bits" mapping; generalised to NUM_DRIVES drives with configurable regions and timeout.

---
 rtl/sdc_pkg.sv | 49 ++++
 rtl/sdc_rr_picker.sv | 56 +++++
 rtl/sdc_drive_arbiter.sv | 174 +++++++++++++++++
 tb/tb_sdc_drive_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdc_pkg.sv
// +----------------------------------------------------------------------------+
// | Package  : sdc_pkg                                                         |
// | Purpose  : Shared types, constants and the round-robin helper used by the  |
// |            SD drive arbiter.                                               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

package sdc_pkg;

  // Absolute SD sector address width.
  localparam int SD_SECTOR_W = 32;

  // Largest drive count the round-robin helper supports.
  localparam int MAX_DRIVES = 8;
  localparam int RR_PTR_W   = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    XFER    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // One-hot winner: first set request bit at or after ptr, wrapping at n.
  function automatic logic [MAX_DRIVES-1:0] next_rr(
    input logic [MAX_DRIVES-1:0] req,
    input logic [RR_PTR_W-1:0]   ptr,
    input int                    n
  );
    logic [MAX_DRIVES-1:0] win;
    logic                  found;
    int                    idx;
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_DRIVES; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if ((k < n) && !found && req[idx[2:0]]) begin
        win[idx[2:0]] = 1'b1;
        found         = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdc_rr_picker.sv
// +----------------------------------------------------------------------------+
// | Module   : sdc_rr_picker                                                   |
// | Purpose  : Combinational round-robin priority encoder. Returns the one-hot |
// |            winner, its binary index and an any-request flag.               |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdc_rr_picker
  import sdc_pkg::*;
#(
  parameter int NUM_DRIVES = 4,
  parameter int IDX_W      = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1
) (
  input  logic [NUM_DRIVES-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic [NUM_DRIVES-1:0] win,
  output logic [IDX_W-1:0]      win_idx,
  output logic                  win_any
);

  logic [MAX_DRIVES-1:0] req8;
  logic [MAX_DRIVES-1:0] win8;
  logic [RR_PTR_W-1:0]   ptr3;

  // Widen to the helper's fixed width and pick the winner.
  always_comb begin
    req8                   = '0;
    ptr3                   = '0;
    req8[NUM_DRIVES-1:0]   = req;
    ptr3[IDX_W-1:0]        = ptr;
    win8                   = next_rr(req8, ptr3, NUM_DRIVES);
  end

  assign win     = win8[NUM_DRIVES-1:0];
  assign win_any = |req;

  // Upper helper bits are always zero when fewer than MAX_DRIVES exist.
  generate
    if (NUM_DRIVES < MAX_DRIVES) begin : g_trim
      logic unused_hi;
      assign unused_hi = ^win8[MAX_DRIVES-1:NUM_DRIVES];
    end
  endgenerate

  // Binary index of the one-hot winner.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_DRIVES; i++) begin
      if (win[i]) win_idx = IDX_W'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdc_drive_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : sdc_drive_arbiter                                               |
// | Purpose  : Round-robin arbiter between per-drive sector requests and the   |
// |            single sd_rw engine; relocates each drive's LBA into its own    |
// |            SD region and routes the byte strobe to the owner only.         |
// | Options  : SDC_LBA_CHECK_EN - reject LBAs at/after drive_size with error.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module sdc_drive_arbiter
  import sdc_pkg::*;
#(
  parameter int NUM_DRIVES     = 4,
  parameter int LBA_W          = 24,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic [NUM_DRIVES*SD_SECTOR_W-1:0] drive_base,
  input  logic [NUM_DRIVES*SD_SECTOR_W-1:0] drive_size,
  input  logic [NUM_DRIVES-1:0]             host_rd,
  input  logic [NUM_DRIVES-1:0]             host_wr,
  input  logic [LBA_W-1:0]                  host_lba,
  output logic                              host_busy,
  output logic [NUM_DRIVES-1:0]             host_done,
  output logic [NUM_DRIVES-1:0]             host_err,
  output logic [NUM_DRIVES-1:0]             grant,
  output logic [NUM_DRIVES-1:0]             host_outen,
  output logic                              sd_rstart,
  output logic                              sd_wstart,
  output logic [SD_SECTOR_W-1:0]            sd_sector,
  input  logic                              sd_busy,
  input  logic                              sd_done,
  input  logic                              sd_outen
);

  localparam int IDX_W = (NUM_DRIVES > 1) ? $clog2(NUM_DRIVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                  state;
  logic [IDX_W-1:0]        ptr;
  logic [IDX_W-1:0]        g;
  logic [CNT_W-1:0]        tcount;
  logic                    range_err;

  logic [NUM_DRIVES-1:0]   req;
  logic [NUM_DRIVES-1:0]   win;
  logic [IDX_W-1:0]        win_idx;
  logic                    win_any;
  logic                    win_rd;
  logic [SD_SECTOR_W-1:0]  base_sel;
  logic [SD_SECTOR_W-1:0]  lba_ext;
  logic [SD_SECTOR_W-1:0]  new_sector;
  logic                    lba_bad;

  assign req = host_rd | host_wr;

  sdc_rr_picker #(
    .NUM_DRIVES (NUM_DRIVES),
    .IDX_W      (IDX_W)
  ) u_picker (
    .req     (req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  // Read wins when the chosen drive holds both levels.
  assign win_rd     = |(host_rd & win);
  assign base_sel   = drive_base[SD_SECTOR_W*win_idx +: SD_SECTOR_W];
  assign lba_ext    = SD_SECTOR_W'(host_lba);
  assign new_sector = base_sel + lba_ext;

`ifdef SDC_LBA_CHECK_EN
  logic [SD_SECTOR_W-1:0] size_sel;
  assign size_sel = drive_size[SD_SECTOR_W*win_idx +: SD_SECTOR_W];
  assign lba_bad  = (lba_ext >= size_sel);
`else
  // Region sizes are not enforced in this build.
  logic unused_size;
  assign unused_size = ^drive_size;
  assign lba_bad     = 1'b0;
`endif

  // Byte strobe reaches only the owning drive, and only while transferring.
  assign host_outen = (state == XFER) ? (grant & {NUM_DRIVES{sd_outen}}) : '0;

  // Arbitration / transfer sequencer with registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      ptr       <= '0;
      g         <= '0;
      tcount    <= '0;
      range_err <= 1'b0;
      grant     <= '0;
      host_busy <= 1'b0;
      host_done <= '0;
      host_err  <= '0;
      sd_rstart <= 1'b0;
      sd_wstart <= 1'b0;
      sd_sector <= '0;
    end else begin
      host_done <= '0;
      host_err  <= '0;
      case (state)
        IDLE: begin
          if (win_any) begin
            g         <= win_idx;
            grant     <= win;
            host_busy <= 1'b1;
            sd_sector <= new_sector;
            tcount    <= '0;
            range_err <= lba_bad;
            sd_rstart <= win_rd & ~lba_bad;
            sd_wstart <= ~win_rd & ~lba_bad;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (range_err) begin
            host_done <= grant;
            host_err  <= grant;
            host_busy <= 1'b0;
            state     <= RELEASE;
          end else if (sd_done) begin
            // Busy and done seen together: finish without entering XFER.
            sd_rstart <= 1'b0;
            sd_wstart <= 1'b0;
            host_done <= grant;
            host_busy <= 1'b0;
            state     <= RELEASE;
          end else if (sd_busy) begin
            sd_rstart <= 1'b0;
            sd_wstart <= 1'b0;
            state     <= XFER;
          end else if (tcount == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            sd_rstart <= 1'b0;
            sd_wstart <= 1'b0;
            host_done <= grant;
            host_err  <= grant;
            host_busy <= 1'b0;
            state     <= RELEASE;
          end else begin
            tcount <= tcount + 1'b1;
          end
        end
        XFER: begin
          if (sd_done) begin
            host_done <= grant;
            host_busy <= 1'b0;
            state     <= RELEASE;
          end
        end
        RELEASE: begin
          // Hold ownership until the drive drops both levels.
          if ((req & grant) == '0) begin
            ptr       <= (g == IDX_W'(NUM_DRIVES - 1)) ? '0 : g + 1'b1;
            grant     <= '0;
            tcount    <= '0;
            range_err <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdc_drive_arbiter.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_sdc_drive_arbiter                                            |
// | Purpose  : Directed self-checking bench for sdc_drive_arbiter.             |
// |            Covers both SDC_LBA_CHECK_EN builds.                            |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_sdc_drive_arbiter;

  localparam int N  = 4;
  localparam int LW = 24;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N*32-1:0] drive_base;
  logic [N*32-1:0] drive_size;
  logic [N-1:0]  host_rd;
  logic [N-1:0]  host_wr;
  logic [LW-1:0] host_lba;
  logic          host_busy;
  logic [N-1:0]  host_done;
  logic [N-1:0]  host_err;
  logic [N-1:0]  grant;
  logic [N-1:0]  host_outen;
  logic          sd_rstart;
  logic          sd_wstart;
  logic [31:0]   sd_sector;
  logic          sd_busy;
  logic          sd_done;
  logic          sd_outen;

  int n_checks = 0;
  int n_fail   = 0;

  sdc_drive_arbiter #(
    .NUM_DRIVES     (N),
    .LBA_W          (LW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .drive_base (drive_base),
    .drive_size (drive_size),
    .host_rd    (host_rd),
    .host_wr    (host_wr),
    .host_lba   (host_lba),
    .host_busy  (host_busy),
    .host_done  (host_done),
    .host_err   (host_err),
    .grant      (grant),
    .host_outen (host_outen),
    .sd_rstart  (sd_rstart),
    .sd_wstart  (sd_wstart),
    .sd_sector  (sd_sector),
    .sd_busy    (sd_busy),
    .sd_done    (sd_done),
    .sd_outen   (sd_outen)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request already applied; checks grant/start, then busy and done.
  task automatic serve(input string tag, input logic [N-1:0] eg, input logic erd,
                       input logic [31:0] esec);
    @(negedge clk);
    check_eq({tag, "_grant"}, 64'(grant), 64'(eg));
    check_eq({tag, "_busy"}, 64'(host_busy), 64'd1);
    check_eq({tag, "_rstart"}, 64'(sd_rstart), 64'(erd));
    check_eq({tag, "_wstart"}, 64'(sd_wstart), 64'(!erd));
    check_eq({tag, "_sector"}, 64'(sd_sector), 64'(esec));
    sd_busy = 1'b1;
    @(negedge clk);
    check_eq({tag, "_startdrop"}, 64'(sd_rstart | sd_wstart), 64'd0);
    sd_busy = 1'b0;
    sd_done = 1'b1;
    @(negedge clk);
    sd_done = 1'b0;
    check_eq({tag, "_done"}, 64'(host_done), 64'(eg));
    check_eq({tag, "_err"}, 64'(host_err), 64'd0);
    check_eq({tag, "_relgrant"}, 64'(grant), 64'(eg));
  endtask

  // Drop the given drives' levels and confirm the grant clears.
  task automatic release_drv(input string tag, input logic [N-1:0] m);
    host_rd = host_rd & ~m;
    host_wr = host_wr & ~m;
    @(negedge clk);
    check_eq({tag, "_released"}, 64'(grant), 64'd0);
  endtask

  initial begin
    int ok_cnt;
    int cyc;

    rstn       = 1'b0;
    host_rd    = '0;
    host_wr    = '0;
    host_lba   = 24'h10;
    sd_busy    = 1'b0;
    sd_done    = 1'b0;
    sd_outen   = 1'b0;
    drive_base = {32'h0003_0000, 32'hFFFF_FFF8, 32'h0000_2000, 32'h0000_1000};
    drive_size = {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd800};

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("rst_grant", 64'(grant), 64'd0);
    check_eq("rst_busy", 64'(host_busy), 64'd0);
    check_eq("rst_start", 64'({sd_rstart, sd_wstart}), 64'd0);
    check_eq("rst_sector", 64'(sd_sector), 64'd0);
    check_eq("rst_done_err", 64'({host_done, host_err}), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Single read on drive 1
    host_rd = 4'b0010;
    @(negedge clk);
    check_eq("rd1_grant", 64'(grant), 64'h2);
    check_eq("rd1_rstart", 64'(sd_rstart), 64'd1);
    check_eq("rd1_wstart", 64'(sd_wstart), 64'd0);
    check_eq("rd1_sector", 64'(sd_sector), 64'h2010);
    repeat (2) @(negedge clk);
    check_eq("rd1_start_held", 64'(sd_rstart), 64'd1);
    sd_busy = 1'b1;
    @(negedge clk);
    check_eq("rd1_start_drop", 64'(sd_rstart), 64'd0);
    ok_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      sd_outen = 1'b1;
      #1;
      if (host_outen == 4'b0010) ok_cnt++;
      @(negedge clk);
      sd_outen = 1'b0;
      #1;
      if (host_outen == 4'b0000) ok_cnt++;
      @(negedge clk);
    end
    check_eq("rd1_outen_mirror", 64'(ok_cnt), 64'd1024);
    sd_busy = 1'b0;
    sd_done = 1'b1;
    @(negedge clk);
    sd_done = 1'b0;
    check_eq("rd1_done", 64'(host_done), 64'h2);
    check_eq("rd1_busy_off", 64'(host_busy), 64'd0);
    @(negedge clk);
    check_eq("rd1_done_once", 64'(host_done), 64'd0);
    release_drv("rd1", 4'b0010);

    // Fresh reset so the pointer starts at drive 0
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Round-robin between drives 0 and 2
    host_rd = 4'b0101;
    serve("rr_a", 4'b0001, 1'b1, 32'h1010);
    release_drv("rr_a", 4'b0001);
    serve("rr_b", 4'b0100, 1'b1, 32'h0000_0008);
    release_drv("rr_b", 4'b0100);
    host_rd = 4'b0101;
    serve("rr_wrap", 4'b0001, 1'b1, 32'h1010);
    host_rd = 4'b0000;
    @(negedge clk);

    // Read and write together on drive 3: read first, grant held until both drop
    host_rd = 4'b1000;
    host_wr = 4'b1000;
    serve("rdwr", 4'b1000, 1'b1, 32'h0003_0010);
    repeat (3) @(negedge clk);
    check_eq("rdwr_hold_grant", 64'(grant), 64'h8);
    check_eq("rdwr_no_start", 64'({sd_rstart, sd_wstart}), 64'd0);
    check_eq("rdwr_busy_off", 64'(host_busy), 64'd0);
    host_rd = 4'b0000;
    repeat (2) @(negedge clk);
    check_eq("rdwr_wr_holds", 64'(grant), 64'h8);
    release_drv("rdwr", 4'b1000);
    host_wr = 4'b1000;
    serve("wr3", 4'b1000, 1'b0, 32'h0003_0010);
    release_drv("wr3", 4'b1000);

    // Timeout on drive 2: sd_busy never rises
    host_rd = 4'b0100;
    @(negedge clk);
    check_eq("to_grant", 64'(grant), 64'h4);
    cyc = 0;
    while (sd_rstart && cyc < 40) begin
      cyc++;
      if (host_done != 0) break;
      @(negedge clk);
    end
    check_eq("to_start_cycles", 64'(cyc), 64'd16);
    check_eq("to_done", 64'(host_done), 64'h4);
    check_eq("to_err", 64'(host_err), 64'h4);
    check_eq("to_rstart_low", 64'(sd_rstart), 64'd0);
    release_drv("to", 4'b0100);

    // Out-of-range LBA on drive 0 (size 800)
    host_lba = 24'd800;
    host_rd  = 4'b0001;
`ifdef SDC_LBA_CHECK_EN
    @(negedge clk);
    check_eq("lba_bad_grant", 64'(grant), 64'h1);
    check_eq("lba_bad_nostart", 64'({sd_rstart, sd_wstart}), 64'd0);
    @(negedge clk);
    check_eq("lba_bad_done", 64'(host_done), 64'h1);
    check_eq("lba_bad_err", 64'(host_err), 64'h1);
    check_eq("lba_bad_nostart2", 64'({sd_rstart, sd_wstart}), 64'd0);
`else
    serve("lba_pass", 4'b0001, 1'b1, 32'h1000 + 32'd800);
`endif
    release_drv("lba800", 4'b0001);
    host_lba = 24'd799;
    host_rd  = 4'b0001;
    serve("lba_ok", 4'b0001, 1'b1, 32'h1000 + 32'd799);
    release_drv("lba_ok", 4'b0001);

    // Asynchronous reset in the middle of a transfer
    host_lba = 24'h10;
    host_rd  = 4'b0010;
    @(negedge clk);
    check_eq("ar_grant", 64'(grant), 64'h2);
    sd_busy = 1'b1;
    @(negedge clk);
    sd_outen = 1'b1;
    #1;
    check_eq("ar_outen", 64'(host_outen), 64'h2);
    #2;
    rstn = 1'b0;
    #1;
    check_eq("ar_grant0", 64'(grant), 64'd0);
    check_eq("ar_busy0", 64'(host_busy), 64'd0);
    check_eq("ar_outen0", 64'(host_outen), 64'd0);
    check_eq("ar_sector0", 64'(sd_sector), 64'd0);
    sd_done = 1'b1;
    @(negedge clk);
    check_eq("ar_nodone", 64'(host_done), 64'd0);
    sd_done  = 1'b0;
    sd_busy  = 1'b0;
    sd_outen = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    serve("ar_after", 4'b0010, 1'b1, 32'h2010);
    release_drv("ar_after", 4'b0010);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
